// File: rtl/boid_frame_writer.sv
// Writes one pixel per boid into the 1-bit display RAM each frame after erasing the previous frame's pixels.
// Define BOID_FRAME_FULL_CLEAR_EN to erase by sweeping the whole frame instead of using the old-address table.
module boid_frame_writer #(
  parameter int MAX_BOIDS    = 32,
  parameter int BOID_BITS    = 5,
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_end,
  output logic [BOID_BITS-1:0]  boid_sel,
  input  logic [9:0]            boid_x,
  input  logic [8:0]            boid_y,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic                  pix_data,
  output logic                  pix_we,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, ERASE, SELECT, WRITE, DONE} state_t;

  localparam logic [BOID_BITS-1:0] LAST_BOID = BOID_BITS'(MAX_BOIDS - 1);
  localparam logic [9:0]           X_LIM     = 10'(VIDEO_WIDTH);
  localparam logic [8:0]           Y_LIM     = 9'(VIDEO_HEIGHT);

  state_t                 state_reg, state_next;
  logic [BOID_BITS-1:0]   idx_reg, idx_next;
  logic [BOID_BITS-1:0]   sel_reg;
  logic                   pending_reg, pending_next;
  logic                   frame_end_reg;
  logic                   start;
  logic                   in_range;
  logic [ADDR_WIDTH-1:0]  y_ext;
  logic [ADDR_WIDTH-1:0]  wr_addr;

  assign start    = frame_end & ~frame_end_reg;
  assign in_range = (boid_x < X_LIM) && (boid_y < Y_LIM);
  // 640*y as (y<<9)+(y<<7) keeps the address path adder-only
  assign y_ext    = ADDR_WIDTH'(boid_y);
  assign wr_addr  = (y_ext << 9) + (y_ext << 7) + ADDR_WIDTH'(boid_x);

`ifdef BOID_FRAME_FULL_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(VIDEO_WIDTH * VIDEO_HEIGHT - 1);
  logic [ADDR_WIDTH-1:0] clr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  clr_reg <= '0;
    else if (state_reg == ERASE) clr_reg <= clr_reg + 1'b1;
    else                        clr_reg <= '0;
  end
`else
  logic [ADDR_WIDTH-1:0] old_addr_reg [MAX_BOIDS];
  logic                  valid_reg    [MAX_BOIDS];

  // Each entry records the pixel its boid lit, so erase touches only those pixels
  for (genvar gi = 0; gi < MAX_BOIDS; gi++) begin : g_old
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        old_addr_reg[gi] <= '0;
        valid_reg[gi]    <= 1'b0;
      end else if (state_reg == WRITE && idx_reg == BOID_BITS'(gi)) begin
        valid_reg[gi] <= in_range;
        if (in_range) old_addr_reg[gi] <= wr_addr;
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      sel_reg       <= '0;
      pending_reg   <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      pending_reg   <= pending_next;
      frame_end_reg <= frame_end;
      if (state_reg == SELECT) sel_reg <= idx_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    boid_sel     = sel_reg;
    pix_addr     = '0;
    pix_data     = 1'b0;
    pix_we       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start || pending_reg) begin
          state_next   = ERASE;
          idx_next     = '0;
          pending_next = 1'b0;
        end
      end
      ERASE: begin
        busy = 1'b1;
        if (start) pending_next = 1'b1;
`ifdef BOID_FRAME_FULL_CLEAR_EN
        pix_addr = clr_reg;
        pix_we   = 1'b1;
        if (clr_reg == LAST_PIX) begin
          state_next = SELECT;
          idx_next   = '0;
        end
`else
        pix_addr = old_addr_reg[idx_reg];
        pix_we   = valid_reg[idx_reg];
        if (idx_reg == LAST_BOID) begin
          state_next = SELECT;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
`endif
      end
      SELECT: begin
        busy       = 1'b1;
        boid_sel   = idx_reg;
        state_next = WRITE;
        if (start) pending_next = 1'b1;
      end
      WRITE: begin
        busy     = 1'b1;
        boid_sel = idx_reg;
        if (start) pending_next = 1'b1;
        if (in_range) begin
          pix_addr = wr_addr;
          pix_data = 1'b1;
          pix_we   = 1'b1;
        end
        if (idx_reg == LAST_BOID) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = SELECT;
        end
      end
      DONE: begin
        done = 1'b1;
        // A queued frame starts straight away rather than detouring through IDLE
        if (start || pending_reg) begin
          state_next   = ERASE;
          idx_next     = '0;
          pending_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Scoreboard bench for boid_frame_writer: expected RAM writes are queued per frame and checked by a monitor.
module tb_boid_frame_writer;

  localparam int NB = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_end;
  logic [4:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic [18:0] pix_addr;
  logic        pix_data;
  logic        pix_we;
  logic        busy;
  logic        done;

  logic [9:0]  bx [NB];
  logic [8:0]  by [NB];

  typedef struct packed {
    logic [18:0] addr;
    logic        data;
    logic [4:0]  sel;
  } wr_t;

  wr_t exp_q [$];
  int  model_old   [NB];
  bit  model_valid [NB];

  int n_checks = 0;
  int n_fail   = 0;
  int busy_total = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_writer dut (
    .clock     (clk),
    .reset     (reset),
    .frame_end (frame_end),
    .boid_sel  (boid_sel),
    .boid_x    (boid_x),
    .boid_y    (boid_y),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .pix_we    (pix_we),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_total++;
      if (done) done_total++;
      if (pix_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write", pix_addr, pix_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", int'(pix_addr), int'(e.addr));
          check("write_data", int'(pix_data), int'(e.data));
          if (e.data) check("write_sel", int'(boid_sel), int'(e.sel));
          $display("write addr=%0d data=%0d sel=%0d", pix_addr, pix_data, boid_sel);
        end
      end else begin
        check("idle_data", int'(pix_data), 0);
      end
    end
  end

  // Queue one frame: erase old pixels, then write in-range boids with index < upto
  task automatic push_frame(input int upto);
    wr_t e;
    for (int i = 0; i < NB; i++) begin
      if (model_valid[i]) begin
        e.addr = 19'(model_old[i]); e.data = 1'b0; e.sel = 5'(i);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < upto; i++) begin
      if (bx[i] < 640 && by[i] < 480) begin
        model_old[i]   = int'(bx[i]) + 640 * int'(by[i]);
        model_valid[i] = 1'b1;
        e.addr = 19'(model_old[i]); e.data = 1'b1; e.sel = 5'(i);
        exp_q.push_back(e);
      end else begin
        model_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_dones(input int d0, input int want, input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      if (done_total - d0 >= want) break;
    end
    if (k == 400) check({name, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_frame(input int hold, input string name);
    int b0, d0;
    b0 = busy_total; d0 = done_total;
    push_frame(NB);
    @(posedge clk); #1 frame_end = 1'b1;
    @(negedge clk); check({name, "_busy_pre"}, int'(busy), 0);
    @(negedge clk); check({name, "_busy_start"}, int'(busy), 1);
    repeat (hold) @(negedge clk);
    frame_end = 1'b0;
    wait_dones(d0, 1, name);
    check({name, "_busy_len"}, busy_total - b0, 96);
    check({name, "_done_cnt"}, done_total - d0, 1);
    check({name, "_queue_left"}, exp_q.size(), 0);
    $display("frame %s busy=%0d dones=%0d", name, busy_total - b0, done_total - d0);
  endtask

  task automatic pulse();
    @(posedge clk); #1 frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
  endtask

  initial begin
    int b0, d0, k;
    reset = 1'b1;
    frame_end = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bx[i] = 10'd700; by[i] = 9'd0;
      model_valid[i] = 1'b0; model_old[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_sel",  int'(boid_sel), 0);
    check("rst_addr", int'(pix_addr), 0);
    check("rst_we",   int'(pix_we),   0);
    check("rst_data", int'(pix_data), 0);
    check("rst_busy", int'(busy),     0);
    check("rst_done", int'(done),     0);
    @(posedge clk); #1 reset = 1'b0;

    bx[3] = 10'd10;  by[3] = 9'd2;   do_frame(0, "f1_boid3");
    bx[3] = 10'd11;                  do_frame(0, "f2_move");
    bx[0] = 10'd639; by[0] = 9'd479; do_frame(0, "f3_corner");
    bx[0] = 10'd640; by[0] = 9'd0;   do_frame(0, "f4_xout");
    bx[0] = 10'd0;   by[0] = 9'd480; do_frame(0, "f5_yout");
    do_frame(500, "f6_hold");

    // Two extra edges while busy collapse into one pending frame
    b0 = busy_total; d0 = done_total;
    push_frame(NB);
    push_frame(NB);
    pulse();
    repeat (20) @(posedge clk);
    pulse();
    repeat (20) @(posedge clk);
    pulse();
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 200) check("pend_first_done_timeout", 0, 1);
    @(negedge clk); check("pend_start_after_done", int'(busy), 1);
    wait_dones(d0, 2, "pend");
    repeat (100) @(posedge clk);
    check("pend_busy_len", busy_total - b0, 192);
    check("pend_done_cnt", done_total - d0, 2);
    check("pend_queue_left", exp_q.size(), 0);
    $display("frame pending busy=%0d dones=%0d", busy_total - b0, done_total - d0);

    // Reset in the WRITE cycle of boid 10
    bx[5] = 10'd20; by[5] = 9'd20;
    bx[10] = 10'd30; by[10] = 9'd30;
    bx[12] = 10'd5;  by[12] = 9'd5;
    push_frame(10);
    pulse();
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy && boid_sel == 5'd10) break;
    end
    if (k == 200) check("rst_mid_timeout", 0, 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("mid_rst_sel",  int'(boid_sel), 0);
    check("mid_rst_addr", int'(pix_addr), 0);
    check("mid_rst_we",   int'(pix_we),   0);
    check("mid_rst_data", int'(pix_data), 0);
    check("mid_rst_busy", int'(busy),     0);
    check("mid_rst_done", int'(done),     0);
    check("mid_rst_queue_left", exp_q.size(), 0);
    $display("reset asserted mid-write sel=10");
    for (int i = 0; i < NB; i++) model_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_frame(0, "f7_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
